// File: rtl/mult_pkg.sv
// +--------------------------------------------------------------------+
// | mult_pkg : shared FSM state type and Booth encodings  (rev 1.0)    |
// +--------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

`default_nettype wire

// File: rtl/module_booth_step.sv
// +--------------------------------------------------------------------+
// | module_booth_step : one combinational radix-2 Booth iteration      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module module_booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q1_o
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    unique case ({q_i[0], q1_i})
      BOOTH_ADD: w_sum = acc_i + m_i;
      BOOTH_SUB: w_sum = acc_i - m_i;
      default:   w_sum = acc_i;
    endcase
  end

  // Arithmetic shift of {ACC, Q, q_1} by one position
  assign acc_o = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign q_o   = {w_sum[0], q_i[WIDTH-1:1]};
  assign q1_o  = q_i[0];

endmodule

`default_nettype wire

// File: rtl/module_mult_booth_seq.sv
// +--------------------------------------------------------------------+
// | module_mult_booth_seq : sequential signed radix-2 Booth multiplier |
// | Option macro: MULT_BOOTH_ZERO_SKIP_EN            rev 1.0           |
// +--------------------------------------------------------------------+
`default_nettype none

module module_mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

  mult_state_t        state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     w_acc_nx;
  logic [WIDTH-1:0]   w_q_nx;
  logic               w_q1_nx;
  logic               w_accept;
  logic               w_skip;

  assign w_accept = start && (state_q != CALC);

`ifdef MULT_BOOTH_ZERO_SKIP_EN
  assign w_skip = (a == '0) || (b == '0);
`else
  assign w_skip = 1'b0;
`endif

  module_booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q1_i  (q1_q),
    .m_i   (m_q),
    .acc_o (w_acc_nx),
    .q_o   (w_q_nx),
    .q1_o  (w_q1_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = {a[WIDTH-1], a};
          q_d     = b;
          q1_d    = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
          // Zero operand: one silent CALC cycle whose exit yields a zero product
          if (w_skip) begin
            q_d   = '0;
            cnt_d = CNT_LAST;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == CNT_LAST) begin
          product_d = {acc_q[WIDTH-1:0], q_q};
          state_d   = DONE;
        end else begin
          acc_d = w_acc_nx;
          q_d   = w_q_nx;
          q1_d  = w_q1_nx;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == CALC) && !(w_accept && w_skip);
    done_d = (state_d == DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_module_mult_booth_seq.sv
// +--------------------------------------------------------------------+
// | tb_module_mult_booth_seq : directed bench for the Booth multiplier |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_module_mult_booth_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [3:0]  a, b;
  logic        busy, done;
  logic [7:0]  product;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;

`ifdef MULT_BOOTH_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  module_mult_booth_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  module_mult_booth_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  // Returns 1 time unit after edge 0 (the edge that samples start)
  task automatic start_op(input logic [3:0] ia, input logic [3:0] ib);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_k, output int lat, output int nbusy, output bit both);
    lat = 0; nbusy = 0; both = 1'b0;
    while (!done && lat < max_k) begin
      if (busy) nbusy++;
      if (busy && done) both = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (busy && done) both = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (product !== 8'h00) begin errors++; $display("FAIL reset_product got %h want 00", product); end
    checks++; if (product8 !== 16'h0000 || busy8 !== 1'b0) begin errors++; $display("FAIL reset_w8 got %h/%b want 0000/0", product8, busy8); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic [7:0] vp [4];
    int lat, nb;
    bit both;
    logic [7:0] held;
    va = '{4'd3, 4'hD, 4'd7, 4'h8};
    vb = '{4'd5, 4'd5, 4'h8, 4'h8};
    vp = '{8'h0F, 8'hF1, 8'hC8, 8'h40};
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      wait_done(20, lat, nb, both);
      checks++; if (lat != 5) begin errors++; $display("FAIL basic%0d_latency got %0d want 5", i, lat); end
      checks++; if (nb != 5) begin errors++; $display("FAIL basic%0d_busy_cycles got %0d want 5", i, nb); end
      checks++; if (both || busy !== 1'b0) begin errors++; $display("FAIL basic%0d_busy_at_done got %b want 0", i, busy); end
      checks++; if (product !== vp[i]) begin errors++; $display("FAIL basic%0d_product got %h want %h", i, product, vp[i]); end
      held = product;
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || product !== vp[i]) begin errors++; $display("FAIL basic%0d_pulse_hold got done=%b prod=%h want 0/%h", i, done, product, vp[i]); end
      if (held !== vp[i]) ; // no-op keep variable used
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    int lat, nb;
    bit both;
    start_op(4'd3, 4'd5);
    @(posedge clk); #1;
    start = 1'b1; a = 4'd7; b = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; a = 4'd0; b = 4'd0;
    wait_done(20, lat, nb, both);
    checks++; if (lat != 3) begin errors++; $display("FAIL ignore_latency got %0d want 3 more edges", lat); end
    checks++; if (product !== 8'h0F) begin errors++; $display("FAIL ignore_product got %h want 0f", product); end
    start = 1'b1; a = 4'd2; b = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got done=%b busy=%b want 0/1", done, busy); end
    wait_done(20, lat, nb, both);
    checks++; if (lat != 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
    checks++; if (product !== 8'h06) begin errors++; $display("FAIL b2b_product got %h want 06", product); end
  endtask

  task automatic test_reset_abort();
    int lat, nb, seen;
    bit both;
    start_op(4'd3, 4'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (product !== 8'h00) begin errors++; $display("FAIL abort_product got %h want 00", product); end
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
    start_op(4'd2, 4'd3);
    wait_done(20, lat, nb, both);
    checks++; if (lat != 5 || product !== 8'h06) begin errors++; $display("FAIL abort_recover got lat=%0d prod=%h want 5/06", lat, product); end
  endtask

  task automatic test_zero();
    int lat, nb;
    bit both;
    int exp_lat;
    int exp_nb;
    exp_lat = ZSKIP ? 1 : 5;
    exp_nb  = ZSKIP ? 0 : 5;
    start_op(4'd0, 4'd6);
    wait_done(20, lat, nb, both);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL zero_a_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (nb != exp_nb) begin errors++; $display("FAIL zero_a_busy got %0d want %0d", nb, exp_nb); end
    checks++; if (product !== 8'h00) begin errors++; $display("FAIL zero_a_product got %h want 00", product); end
    start_op(4'd3, 4'd3);
    wait_done(20, lat, nb, both);
    start_op(4'd5, 4'd0);
    wait_done(20, lat, nb, both);
    checks++; if (lat != exp_lat || product !== 8'h00) begin errors++; $display("FAIL zero_b got lat=%0d prod=%h want %0d/00", lat, product, exp_lat); end
  endtask

  task automatic test_sweep4();
    int lat, nb;
    bit both;
    logic signed [7:0] r;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        start_op(4'(i), 4'(j));
        wait_done(20, lat, nb, both);
        r = $signed(4'(i)) * $signed(4'(j));
        checks++;
        if (done !== 1'b1 || product !== r) begin
          errors++;
          $display("FAIL sweep4 a=%h b=%h got %h done=%b want %h", 4'(i), 4'(j), product, done, r);
        end
      end
    end
  endtask

  task automatic test_sweep8();
    int k;
    logic signed [15:0] r;
    for (int n = 0; n < 44; n++) begin
      @(negedge clk);
      case (n)
        0: begin a8 = 8'h80; b8 = 8'h80; end
        1: begin a8 = 8'h7F; b8 = 8'h80; end
        2: begin a8 = 8'hFF; b8 = 8'hFF; end
        3: begin a8 = 8'h7F; b8 = 8'h7F; end
        default: begin a8 = 8'($urandom); b8 = 8'($urandom); end
      endcase
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      k = 0;
      while (!done8 && k < 30) begin
        @(posedge clk); #1;
        k++;
      end
      r = $signed(a8) * $signed(b8);
      checks++;
      if (done8 !== 1'b1 || product8 !== r || k != 9) begin
        errors++;
        $display("FAIL sweep8 a=%h b=%h got %h lat=%0d want %h lat=9", a8, b8, product8, k, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_and_back_to_back();
    test_reset_abort();
    test_zero();
    test_sweep4();
    test_sweep8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
